// File: rtl/vertex_ram_mp.sv
// Banked vertex store for SSSP: cacheline fills, tagged 2-cycle reads,
// a 2-stage min-update read-modify-write port and a clear-to-infinity engine.
module vertex_ram_mp #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned VERT_W = 32,
  parameter int unsigned CL_W   = 512,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [CL_W-1:0]   fill_cl,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rsp_valid,
  output logic [VERT_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [VERT_W-1:0] upd_data,
  input  logic              clear_start,
  output logic              clear_busy
);
  localparam int unsigned LANES = CL_W / VERT_W;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned LW    = ADDR_W - LB;
  localparam int unsigned LINES = 1 << LW;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;

  logic              u1_valid_q, u2_valid_q;
  logic [ADDR_W-1:0] u1_addr_q, u2_addr_q;
  logic [VERT_W-1:0] u1_data_q, u2_data_q;

  logic              r1_valid_q, r1_fwd_q;
  logic [LB-1:0]     r1_lane_q;
  logic [TAG_W-1:0]  r1_tag_q;
  logic [VERT_W-1:0] r1_fwd_data_q;

  logic [VERT_W-1:0] bank_rd [LANES];

  logic              idle, fill_acc, upd_acc, rd_acc, clr_we;
  logic [LB-1:0]     u1_lane;
  logic [VERT_W-1:0] u1_old, u1_new;
  logic              u1_we;
  logic [LW-1:0]     wr_line, rd_line;
  logic              unused_fill_lane;

  assign unused_fill_lane = ^fill_addr[LB-1:0];

  assign idle       = (state_q == ST_IDLE);
  assign clear_busy = !idle;
  assign fill_ready = idle && !u1_valid_q;
  assign upd_ready  = idle && !fill_valid;
  assign rd_ready   = idle && !upd_valid;
  assign fill_acc   = fill_valid && fill_ready;
  assign upd_acc    = upd_valid && upd_ready;
  assign rd_acc     = rd_valid && rd_ready;
  // Clear writes wait for an in-flight update commit so it never collides
  assign clr_we     = (state_q == ST_CLEAR) && !u1_valid_q;

  // U1 compare: the previous commit is not yet visible in the bank output
  assign u1_lane = u1_addr_q[LB-1:0];
  assign u1_old  = (u2_valid_q && (u2_addr_q == u1_addr_q)) ? u2_data_q : bank_rd[u1_lane];
  assign u1_we   = u1_valid_q && (u1_data_q < u1_old);
  assign u1_new  = u1_we ? u1_data_q : u1_old;

  assign rd_line = upd_acc ? upd_addr[ADDR_W-1:LB] : rd_addr[ADDR_W-1:LB];

  always_comb begin
    wr_line = u1_addr_q[ADDR_W-1:LB];
    if (clr_we)        wr_line = cnt_q;
    else if (fill_acc) wr_line = fill_addr[ADDR_W-1:LB];
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [VERT_W-1:0] mem [LINES];
    logic [VERT_W-1:0] q;
    logic              we;
    logic [VERT_W-1:0] wdata;

    always_comb begin
      we    = clr_we || fill_acc || (u1_we && (u1_lane == LB'(b)));
      wdata = u1_data_q;
      if (clr_we)        wdata = '1;
      else if (fill_acc) wdata = fill_cl[b*VERT_W +: VERT_W];
    end

    always_ff @(posedge clk) begin
      if (we) mem[wr_line] <= wdata;
      q <= mem[rd_line];
    end

    assign bank_rd[b] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_we) begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == '1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Update and read pipelines; read forwards an update committing in its accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_valid_q    <= 1'b0;
      u1_addr_q     <= '0;
      u1_data_q     <= '0;
      u2_valid_q    <= 1'b0;
      u2_addr_q     <= '0;
      u2_data_q     <= '0;
      r1_valid_q    <= 1'b0;
      r1_fwd_q      <= 1'b0;
      r1_lane_q     <= '0;
      r1_tag_q      <= '0;
      r1_fwd_data_q <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_tag       <= '0;
    end else begin
      u1_valid_q <= upd_acc;
      if (upd_acc) begin
        u1_addr_q <= upd_addr;
        u1_data_q <= upd_data;
      end
      u2_valid_q <= u1_valid_q;
      u2_addr_q  <= u1_addr_q;
      u2_data_q  <= u1_new;
      r1_valid_q <= rd_acc;
      if (rd_acc) begin
        r1_lane_q     <= rd_addr[LB-1:0];
        r1_tag_q      <= rd_tag;
        r1_fwd_q      <= u1_valid_q && (u1_addr_q == rd_addr);
        r1_fwd_data_q <= u1_new;
      end
      rsp_valid <= r1_valid_q;
      if (r1_valid_q) begin
        rsp_data <= r1_fwd_q ? r1_fwd_data_q : bank_rd[r1_lane_q];
        rsp_tag  <= r1_tag_q;
      end
    end
  end
endmodule

// File: tb/tb_vertex_ram_mp.sv
// Randomised scoreboard bench for vertex_ram_mp against an array-based model.
module tb_vertex_ram_mp;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned VERT_W = 32;
  localparam int unsigned CL_W   = 512;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned LANES  = 16;
  localparam int unsigned DEPTH  = 256;

  logic              clk, rst_n;
  logic              fill_valid, fill_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic [CL_W-1:0]   fill_cl;
  logic              rd_valid, rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [TAG_W-1:0]  rd_tag;
  logic              rsp_valid;
  logic [VERT_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              upd_valid, upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic [VERT_W-1:0] upd_data;
  logic              clear_start, clear_busy;

  vertex_ram_mp #(.ADDR_W(ADDR_W), .VERT_W(VERT_W), .CL_W(CL_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_cl(fill_cl),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [VERT_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              exp_q[$];
  logic [VERT_W-1:0] model [DEPTH];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  logic              last_fr, last_ur, last_rr, last_fa, last_ua, last_ra;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response is popped from the scoreboard and compared
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got tag %0h data %0h, required no response", rsp_tag, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_tag", rsp_tag, e.tag);
        check("rsp_cycle", cyc, e.due);
      end
    end else if (rst_n && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL rsp_missing: got no response at cycle %0d, required tag %0h data %0h", cyc, e.tag, e.data);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '1;
  endtask

  task automatic drive(input logic fv, input logic [ADDR_W-1:0] fa, input logic [CL_W-1:0] fcl,
                       input logic rv, input logic [ADDR_W-1:0] ra, input logic [TAG_W-1:0] rt,
                       input logic uv, input logic [ADDR_W-1:0] ua, input logic [VERT_W-1:0] ud,
                       input logic cs);
    exp_t e;
    logic [ADDR_W-1:0] va;
    @(negedge clk);
    fill_valid = fv; fill_addr = fa; fill_cl = fcl;
    rd_valid = rv; rd_addr = ra; rd_tag = rt;
    upd_valid = uv; upd_addr = ua; upd_data = ud;
    clear_start = cs;
    #1;
    last_fr = fill_ready; last_ur = upd_ready; last_rr = rd_ready;
    last_fa = fv && fill_ready;
    last_ua = uv && upd_ready;
    last_ra = rv && rd_ready;
    // A read observes everything accepted before its own cycle
    if (last_ra) begin
      e.tag = rt; e.data = model[ra]; e.due = cyc + 2;
      exp_q.push_back(e);
    end
    if (last_fa)
      for (int i = 0; i < LANES; i++) begin
        va = {fa[ADDR_W-1:4], 4'(i)};
        model[va] = fcl[i*VERT_W +: VERT_W];
      end
    if (last_ua && ud < model[ua]) model[ua] = ud;
    if (cs && !clear_busy) model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_fill(input logic [ADDR_W-1:0] a, input logic [CL_W-1:0] cl);
    drive(1, a, cl, 0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
    drive(0, '0, '0, 1, a, t, 0, '0, '0, 0);
  endtask

  task automatic do_upd(input logic [ADDR_W-1:0] a, input logic [VERT_W-1:0] d);
    drive(0, '0, '0, 0, '0, '0, 1, a, d, 0);
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (clear_busy && n < 100);
    check(name, n, 16);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    fill_valid = 0; rd_valid = 0; upd_valid = 0; clear_start = 0;
    exp_q.delete();
    model_clear();
    #1;
    check("rst_clear_busy", clear_busy, 1);
    check("rst_ready", {fill_ready, rd_ready, upd_ready}, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_tag, rsp_data}, 0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    count_clear("reset_clear_cycles");
  endtask

  task automatic clear_and_wait();
    drive(0, '0, '0, 0, '0, '0, 0, '0, '0, 1);
    idle(1);
    check("clear_busy_set", clear_busy, 1);
    count_clear("clear_cycles");
  endtask

  initial begin : stim
    logic [CL_W-1:0] cl;
    logic fv, rv, uv, cs;
    logic [ADDR_W-1:0] ua;
    rst_n = 1'b0;
    fill_valid = 0; fill_addr = '0; fill_cl = '0;
    rd_valid = 0; rd_addr = '0; rd_tag = '0;
    upd_valid = 0; upd_addr = '0; upd_data = '0;
    clear_start = 0;
    do_reset(2);

    // Cleared vertex reads as infinity
    do_read(8'h37, 4'h3);
    idle(3);

    // Fill a line, stream it back
    for (int i = 0; i < LANES; i++) cl[i*VERT_W +: VERT_W] = VERT_W'(i + 100);
    do_fill(8'h20, cl);
    for (int i = 0; i < LANES; i++) begin
      do_read(8'h20 + 8'(i), 4'(i));
      check("stream_rd_accept", last_ra, 1);
    end
    idle(3);

    // Back-to-back min updates, then a read right behind them
    clear_and_wait();
    do_upd(8'h05, 50);  check("upd_accept", last_ua, 1);
    do_upd(8'h05, 70);  check("upd_accept", last_ua, 1);
    do_upd(8'h05, 30);  check("upd_accept", last_ua, 1);
    do_read(8'h05, 4'h9);
    do_upd(8'h05, 32'hFFFF_FFFF);
    idle(1);
    do_read(8'h05, 4'hA);
    idle(3);

    // Fill beats update; fill blocked while the update sits in U1
    for (int i = 0; i < LANES; i++) cl[i*VERT_W +: VERT_W] = VERT_W'(i + 1);
    drive(1, 8'h80, cl, 0, '0, '0, 1, 8'h85, 32'd0, 0);
    check("fill_wins_fill", last_fa, 1);
    check("fill_wins_upd_ready", last_ur, 0);
    do_upd(8'h85, 32'd0);
    check("upd_after_fill", last_ua, 1);
    do_fill(8'h90, cl);
    check("fill_blocked_u1", last_fr, 0);
    do_fill(8'h90, cl);
    check("fill_after_u1", last_fa, 1);
    drive(0, '0, '0, 1, 8'h85, 4'h1, 1, 8'h86, 32'd3, 0);
    check("upd_wins_rd", last_rr, 0);
    idle(1);
    do_read(8'h85, 4'h2);
    do_read(8'h86, 4'h3);
    idle(3);

    // Read racing a fill of its own line returns old data
    for (int i = 0; i < LANES; i++) cl[i*VERT_W +: VERT_W] = VERT_W'(i + 200);
    do_fill(8'h40, cl);
    for (int i = 0; i < LANES; i++) cl[i*VERT_W +: VERT_W] = VERT_W'(i + 300);
    drive(1, 8'h40, cl, 1, 8'h40, 4'h5, 0, '0, '0, 0);
    check("fill_rd_both", {last_fa, last_ra}, 2'b11);
    do_read(8'h40, 4'h6);
    idle(3);

    // Fill together with clear_start, then reset in the middle of the clear
    for (int i = 0; i < LANES; i++) cl[i*VERT_W +: VERT_W] = 32'd7;
    drive(1, 8'h60, cl, 0, '0, '0, 0, '0, '0, 1);
    check("fill_with_clear", last_fa, 1);
    idle(5);
    check("mid_clear_busy", clear_busy, 1);
    do_reset(1);
    for (int i = 0; i < LANES; i++) do_read(8'h60 + 8'(i), 4'(i));
    do_read(8'h05, 4'h7);
    do_read(8'h20, 4'h8);
    idle(3);

    // Random traffic concentrated on a few lines to stress forwarding
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < LANES; i++) cl[i*VERT_W +: VERT_W] = $urandom;
      fv = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 1) == 0);
      uv = ($urandom_range(0, 2) != 0);
      cs = ($urandom_range(0, 299) == 0);
      ua = 8'($urandom_range(0, 31));
      drive(fv, 8'($urandom_range(0, 47)), cl,
            rv, 8'($urandom_range(0, 31)), 4'($urandom),
            uv, ua, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : 32'($urandom),
            cs);
    end
    idle(6);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
